// File: rtl/ps2_editor_campos_pkg.sv
// Shared PS/2 set-2 scancodes, editor state encoding and key-decode helpers
// for the numeric field editor.
package ps2_editor_campos_pkg;

    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] PS2_D0    = 8'h45;
    localparam logic [7:0] PS2_D1    = 8'h16;
    localparam logic [7:0] PS2_D2    = 8'h1E;
    localparam logic [7:0] PS2_D3    = 8'h26;
    localparam logic [7:0] PS2_D4    = 8'h25;
    localparam logic [7:0] PS2_D5    = 8'h2E;
    localparam logic [7:0] PS2_D6    = 8'h36;
    localparam logic [7:0] PS2_D7    = 8'h3D;
    localparam logic [7:0] PS2_D8    = 8'h3E;
    localparam logic [7:0] PS2_D9    = 8'h46;

    localparam logic [7:0] PS2_F1    = 8'h05;
    localparam logic [7:0] PS2_F2    = 8'h06;
    localparam logic [7:0] PS2_F3    = 8'h04;
    localparam logic [7:0] PS2_F4    = 8'h0C;

    localparam logic [7:0] PS2_ENTER = 8'h5A;
    localparam logic [7:0] PS2_ESC   = 8'h76;
    localparam logic [7:0] PS2_BKSP  = 8'h66;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EDIT = 1'b1
    } estado_t;

    typedef struct packed {
        logic       valido;
        logic [3:0] valor;
    } digito_t;

    function automatic digito_t decode_digito(input logic [7:0] code);
        digito_t d;
        d = '0;
        d.valido = 1'b1;
        case (code)
            PS2_D0:  d.valor = 4'd0;
            PS2_D1:  d.valor = 4'd1;
            PS2_D2:  d.valor = 4'd2;
            PS2_D3:  d.valor = 4'd3;
            PS2_D4:  d.valor = 4'd4;
            PS2_D5:  d.valor = 4'd5;
            PS2_D6:  d.valor = 4'd6;
            PS2_D7:  d.valor = 4'd7;
            PS2_D8:  d.valor = 4'd8;
            PS2_D9:  d.valor = 4'd9;
            default: d = '0;
        endcase
        return d;
    endfunction

    // Returns k for key F<k>, 0 for anything that is not F1..F4.
    function automatic logic [2:0] decode_tecla_f(input logic [7:0] code);
        logic [2:0] k;
        case (code)
            PS2_F1:  k = 3'd1;
            PS2_F2:  k = 3'd2;
            PS2_F3:  k = 3'd3;
            PS2_F4:  k = 3'd4;
            default: k = 3'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_filtro_prefijo.sv
// Strips F0 (break) and E0 (extended) prefixes from the scancode stream and
// emits a registered one-cycle make_tick for each plain or extended make code.
module ps2_filtro_prefijo
    import ps2_editor_campos_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_done_tick,
    input  logic [7:0] dout,
    output logic       make_tick,
    output logic [7:0] make_code,
    output logic       make_ext
);

    logic brk_pend;
    logic ext_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            make_tick <= 1'b0;
            make_code <= 8'h00;
            make_ext  <= 1'b0;
        end else begin
            make_tick <= 1'b0;
            if (rx_done_tick) begin
                if (dout == PS2_BRK) begin
                    brk_pend <= 1'b1;
                end else if (dout == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else begin
                    // A byte following F0 is a key release and never reaches the editor.
                    make_tick <= ~brk_pend;
                    make_code <= dout;
                    make_ext  <= ext_pend;
                    brk_pend  <= 1'b0;
                    ext_pend  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_editor_campos.sv
// Keyboard-driven numeric editor: F-keys pick a field, digits accumulate a
// decimal value, Enter commits it into the field register bank.
module ps2_editor_campos
    import ps2_editor_campos_pkg::*;
#(
    parameter int NUM_CAMPOS = 3,
    parameter int ANCHO      = 5,
    parameter int VALOR_MAX  = (1 << ANCHO) - 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_done_tick,
    input  logic [7:0]                  dout,
    output logic [NUM_CAMPOS*ANCHO-1:0] campos,
    output logic [1:0]                  campo_activo,
    output logic                        editando,
    output logic                        datos_listos,
    output logic                        error
);

    localparam int AW = ANCHO + 4;

    logic                        make_tick;
    logic [7:0]                  make_code;
    logic                        make_ext;

    estado_t                     state, state_n;
    logic [ANCHO-1:0]            acc, acc_n;
    logic [1:0]                  campo_n;
    logic [NUM_CAMPOS*ANCHO-1:0] campos_n;
    logic                        error_n;
    logic                        listo_n;

    digito_t                     dig;
    logic [2:0]                  tecla_f;
    logic                        tecla_f_ok;
    logic [AW-1:0]               acc_ext;
    logic [AW-1:0]               nxt;

    ps2_filtro_prefijo u_filtro (
        .clk          (clk),
        .rst          (rst),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .make_tick    (make_tick),
        .make_code    (make_code),
        .make_ext     (make_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            acc          <= '0;
            campo_activo <= 2'd0;
            campos       <= '0;
            error        <= 1'b0;
            datos_listos <= 1'b0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            campo_activo <= campo_n;
            campos       <= campos_n;
            error        <= error_n;
            datos_listos <= listo_n;
        end
    end

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        campo_n    = campo_activo;
        campos_n   = campos;
        error_n    = error;
        listo_n    = 1'b0;

        dig        = decode_digito(make_code);
        tecla_f    = decode_tecla_f(make_code);
        tecla_f_ok = (tecla_f != 3'd0) && (int'(tecla_f) <= NUM_CAMPOS);
        acc_ext    = {4'b0000, acc};
        nxt        = (acc_ext << 3) + (acc_ext << 1) + AW'(dig.valor);

        // Extended codes (E0 xx) are never editor keys, so they fall through untouched.
        if (make_tick && !make_ext) begin
            if (tecla_f_ok) begin
                state_n = S_EDIT;
                campo_n = 2'(tecla_f - 3'd1);
                acc_n   = '0;
                error_n = 1'b0;
            end else if (state == S_EDIT) begin
                if (dig.valido) begin
                    if (nxt <= AW'(VALOR_MAX)) begin
                        acc_n = nxt[ANCHO-1:0];
                    end else begin
                        error_n = 1'b1;
                    end
                end else if (make_code == PS2_BKSP) begin
                    acc_n = ANCHO'(acc_ext / AW'(10));
                end else if (make_code == PS2_ENTER) begin
                    for (int k = 0; k < NUM_CAMPOS; k++) begin
                        if (campo_activo == 2'(k)) begin
                            campos_n[k*ANCHO +: ANCHO] = acc;
                        end
                    end
                    listo_n = 1'b1;
                    state_n = S_IDLE;
                end else if (make_code == PS2_ESC) begin
                    state_n = S_IDLE;
                end
            end
        end
    end

    assign editando = (state == S_EDIT);

endmodule
